// File: rtl/fourier_rns_ctrl.sv
// rtl/fourier_rns_ctrl.sv - frame sequencer for the RNS DFT core
// Loads N samples into the core, runs compute until done or timeout, then drains N results.
module fourier_rns_ctrl #(
    parameter int          N       = 100,
    parameter logic [31:0] TIMEOUT = 32'd20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_re,
    output logic [31:0] out_im,
    output logic        out_last,
    output logic        busy,
    output logic        frame_done,
    output logic        error,
    output logic [31:0] run_cycles,
    output logic        core_reset,
    output logic [31:0] core_addr,
    output logic [31:0] core_x_rns,
    output logic [1:0]  core_op,
    input  logic [31:0] core_y_re,
    input  logic [31:0] core_y_im,
    input  logic        core_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_RUN,
        S_RD_ISSUE,
        S_RD_WAIT
    } state_t;

    localparam logic [1:0]  OP_IDLE    = 2'b00;
    localparam logic [1:0]  OP_WRITE   = 2'b01;
    localparam logic [1:0]  OP_COMPUTE = 2'b10;
    localparam logic [1:0]  OP_READ    = 2'b11;
    localparam logic [31:0] LAST_IDX   = 32'(N - 1);
    localparam logic [31:0] RUN_LIMIT  = TIMEOUT - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] run_cycles_q, run_cycles_d;
    logic        error_q, error_d;
    logic        frame_done_q, frame_done_d;
    logic        cnt_last;

    assign cnt_last = (cnt_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 32'd0;
            run_cycles_q <= 32'd0;
            error_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_cycles_q <= run_cycles_d;
            error_q      <= error_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_cycles_d = run_cycles_q;
        error_d      = error_q;
        frame_done_d = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        core_op      = OP_IDLE;
        core_addr    = 32'd0;
        core_x_rns   = 32'd0;

        unique case (state_q)
            S_IDLE: begin
                // The triggering sample stays on the bus; it is taken in LOAD.
                if (in_valid) begin
                    state_d = S_CLR;
                    error_d = 1'b0;
                    cnt_d   = 32'd0;
                end
            end
            S_CLR: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    core_op    = OP_WRITE;
                    core_addr  = cnt_q;
                    core_x_rns = in_data;
                    if (cnt_last) begin
                        cnt_d        = 32'd0;
                        run_cycles_d = 32'd0;
                        state_d      = S_RUN;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_RUN: begin
                core_op      = OP_COMPUTE;
                run_cycles_d = run_cycles_q + 32'd1;
                if (core_done) begin
                    core_op = OP_IDLE;
                    state_d = S_RD_ISSUE;
                end else if (run_cycles_q == RUN_LIMIT) begin
                    error_d = 1'b1;
                    state_d = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                core_op   = OP_READ;
                core_addr = cnt_q;
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Address is held so a stalled sink sees a stable re-read.
                core_op   = OP_READ;
                core_addr = cnt_q;
                out_valid = 1'b1;
                out_last  = cnt_last;
                if (out_ready) begin
                    if (cnt_last) begin
                        frame_done_d = 1'b1;
                        cnt_d        = 32'd0;
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 32'd1;
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_re     = core_y_re;
    assign out_im     = core_y_im;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;
    assign error      = error_q;
    assign run_cycles = run_cycles_q;
    assign core_reset = reset | (state_q == S_CLR);

endmodule

// File: tb/tb_fourier_rns_ctrl.sv
// tb/tb_fourier_rns_ctrl.sv - randomized self-checking bench for fourier_rns_ctrl
module tb_fourier_rns_ctrl;

    localparam int N       = 4;
    localparam int TMO     = 50;
    localparam int RUN_LEN = N * (N + 1) + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_re;
    logic [31:0] out_im;
    logic        out_last;
    logic        busy;
    logic        frame_done;
    logic        error;
    logic [31:0] run_cycles;
    logic        core_reset;
    logic [31:0] core_addr;
    logic [31:0] core_x_rns;
    logic [1:0]  core_op;
    logic [31:0] core_y_re;
    logic [31:0] core_y_im;
    logic        core_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fourier_rns_ctrl #(.N(N), .TIMEOUT(32'(TMO))) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done),
        .error      (error),
        .run_cycles (run_cycles),
        .core_reset (core_reset),
        .core_addr  (core_addr),
        .core_x_rns (core_x_rns),
        .core_op    (core_op),
        .core_y_re  (core_y_re),
        .core_y_im  (core_y_im),
        .core_done  (core_done)
    );

    // Core stand-in: result k is {k,k,k,k} on the real part and the stored sample on the imaginary part.
    logic        never_done;
    int          ccnt;
    logic [31:0] xm [N];

    always @(posedge clk) begin
        if (core_reset) ccnt <= 0;
        else if (core_op == 2'b10) ccnt <= ccnt + 1;
        if (core_op == 2'b01) xm[core_addr[1:0]] <= core_x_rns;
        if (core_op == 2'b11) begin
            core_y_re <= core_addr * 32'h01010101;
            core_y_im <= xm[core_addr[1:0]];
        end
    end

    assign core_done = !never_done && (ccnt >= N * (N + 1));

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input bit fixed, input bit gaps, input int bp_idx, input bit no_done);
        logic [31:0] s [N];
        logic [31:0] hold;
        int          len;
        int          g;
        never_done = no_done;
        for (int i = 0; i < N; i++) s[i] = fixed ? 32'(i + 1) * 32'h01010101 : $urandom;

        @(negedge clk); in_valid = 1'b1; in_data = s[0]; #1;
        expect_eq("idle_in_ready", in_ready, 0);
        expect_eq("idle_busy", busy, 0);
        @(negedge clk); #1;
        expect_eq("clr_core_reset", core_reset, 1);
        expect_eq("clr_in_ready", in_ready, 0);
        expect_eq("clr_busy", busy, 1);
        expect_eq("clr_error", error, 0);
        expect_eq("clr_core_op", core_op, 0);

        for (int i = 0; i < N; i++) begin
            g = gaps ? ((i == 1) ? 2 : int'($urandom_range(0, 2))) : 0;
            for (int j = 0; j < g; j++) begin
                @(negedge clk); in_valid = 1'b0; in_data = $urandom; #1;
                expect_eq("gap_in_ready", in_ready, 1);
                expect_eq("gap_core_op", core_op, 0);
            end
            @(negedge clk); in_valid = 1'b1; in_data = s[i]; #1;
            expect_eq("load_in_ready", in_ready, 1);
            expect_eq("load_core_op", core_op, 1);
            expect_eq("load_core_addr", core_addr, 32'(i));
            expect_eq("load_core_x_rns", core_x_rns, s[i]);
        end

        len = no_done ? TMO : RUN_LEN;
        for (int c = 0; c < len; c++) begin
            @(negedge clk); in_valid = 1'($urandom_range(0, 1)); in_data = $urandom; #1;
            expect_eq("run_in_ready", in_ready, 0);
            expect_eq("run_busy", busy, 1);
            expect_eq("run_core_op", core_op, (c == len - 1 && !no_done) ? 32'd0 : 32'd2);
            expect_eq("run_core_addr", core_addr, 0);
        end

        for (int k = 0; k < N; k++) begin
            @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
            expect_eq("iss_out_valid", out_valid, 0);
            expect_eq("iss_core_op", core_op, 3);
            expect_eq("iss_core_addr", core_addr, 32'(k));
            if (k == 0) begin
                expect_eq("run_cycles", run_cycles, 32'(len));
                expect_eq("run_error", error, 32'(no_done));
            end
            @(negedge clk); out_ready = (k != bp_idx); #1;
            if (k == bp_idx) begin
                hold = out_re;
                expect_eq("bp_out_valid", out_valid, 1);
                for (int j = 1; j < 5; j++) begin
                    @(negedge clk); #1;
                    expect_eq("bp_out_valid", out_valid, 1);
                    expect_eq("bp_out_re_stable", out_re, hold);
                    expect_eq("bp_core_addr", core_addr, 32'(k));
                end
                @(negedge clk); out_ready = 1'b1; #1;
                expect_eq("bp_out_re_final", out_re, hold);
            end
            expect_eq("wait_out_valid", out_valid, 1);
            expect_eq("wait_out_last", out_last, 32'(k == N - 1));
            expect_eq("wait_core_addr", core_addr, 32'(k));
            if (!no_done) begin
                expect_eq("out_re", out_re, 32'(k) * 32'h01010101);
                expect_eq("out_im", out_im, s[k]);
            end
        end

        @(negedge clk); #1;
        expect_eq("done_pulse", frame_done, 1);
        expect_eq("done_busy", busy, 0);
        expect_eq("done_error", error, 32'(no_done));
        expect_eq("done_out_valid", out_valid, 0);
        @(negedge clk); #1;
        expect_eq("done_pulse_end", frame_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1; never_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            expect_eq("rst_core_reset", core_reset, 1);
            expect_eq("rst_core_op", core_op, 0);
            expect_eq("rst_in_ready", in_ready, 0);
            expect_eq("rst_out_valid", out_valid, 0);
            expect_eq("rst_out_last", out_last, 0);
            expect_eq("rst_busy", busy, 0);
            expect_eq("rst_frame_done", frame_done, 0);
            expect_eq("rst_error", error, 0);
            expect_eq("rst_run_cycles", run_cycles, 0);
            expect_eq("rst_core_addr", core_addr, 0);
            expect_eq("rst_core_x_rns", core_x_rns, 0);
        end
        @(negedge clk); reset = 1'b0; #1;
        expect_eq("idle_core_reset", core_reset, 0);
        expect_eq("idle_core_op", core_op, 0);
        expect_eq("idle_busy0", busy, 0);

        run_frame(1'b1, 1'b0, 2, 1'b0);
        run_frame(1'b0, 1'b1, -1, 1'b0);
        run_frame(1'b0, 1'b0, int'($urandom_range(0, N - 1)), 1'b1);
        run_frame(1'b0, 1'b1, int'($urandom_range(0, N - 1)), 1'b0);

        @(negedge clk); in_valid = 1'b1; in_data = $urandom; #1;
        @(negedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = $urandom; #1;
            expect_eq("mr_core_op", core_op, 1);
        end
        @(negedge clk); in_valid = 1'b0; reset = 1'b1; #1;
        expect_eq("mr_core_reset", core_reset, 1);
        @(negedge clk); reset = 1'b0; #1;
        expect_eq("mr_busy", busy, 0);
        expect_eq("mr_in_ready", in_ready, 0);
        expect_eq("mr_core_op", core_op, 0);
        expect_eq("mr_run_cycles", run_cycles, 0);
        expect_eq("mr_error", error, 0);

        run_frame(1'b0, 1'b0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fourier_rns_ctrl.md
# fourier_rns_ctrl

Frame sequencer for the RNS DFT core. It accepts N RNS-encoded samples on a valid/ready input stream and loads them into the core with write operations. It then runs the core's compute phase until it signals done, and reads the N complex results back out on a valid/ready output stream. It sits between the sample source/sink and the core. It owns the core's reset, addr, x_rns and operation pins exclusively.

## Interface
- N, default 100: samples per frame; must equal the core's n.
- TIMEOUT, default 32'd20000: maximum RUN cycles before error; must be ≥ N*(N+1)+2.
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  reset; synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts sample.
- in_data  in  32  RNS sample {r251,r241,r239,r233}.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_re, out_im  out  32 each  RNS real/imag result.
- out_last  out  1  marks result index N-1.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after last result accepted.
- error  out  1  sticky compute timeout flag; cleared on reset or next frame start.
- run_cycles  out  32  RUN-state cycle count of the most recent frame; held until the next RUN.
- core_reset  out  1  to core reset.
- core_addr  out  32  to core addr.
- core_x_rns  out  32  to core x_rns.
- core_op  out  2  to core operation: 00 idle, 01 write, 10 compute, 11 read.
- core_y_re, core_y_im  in  32 each  from core (registered in core, one-cycle read latency).
- core_done  in  1  from core.

## Operation
- States: IDLE, CLR, LOAD, RUN, RD_ISSUE, RD_WAIT. Index counter cnt is 32 bits and saturates at no value; its range is 0..N-1.
- Outputs are combinational decodes of state/cnt/inputs: in_ready, out_valid, out_last, core_*. Everything else is registered.
- IDLE: core_op=00, in_ready=0.
  - If in_valid=1: go to CLR, clear error, cnt←0. The sample is not consumed.
- CLR: core_reset=1, core_op=00, for exactly 1 cycle, then LOAD. This clears the core's sticky done, its indices and its accumulators.
- LOAD: in_ready=1.
  - On in_valid&in_ready: core_op=01, core_addr=cnt, core_x_rns=in_data (same cycle), cnt←cnt+1.
  - Otherwise core_op=00.
  - After the sample with cnt=N-1 is accepted: cnt←0, run_cycles←0, go to RUN.
- RUN: core_op=10, core_addr=0. run_cycles increments every RUN cycle.
  - If core_done=1: go to RD_ISSUE. core_op=00 in that cycle.
  - Else if run_cycles=TIMEOUT-1: error←1, go to RD_ISSUE. The results are then undefined but still drained.
- RD_ISSUE: core_op=11, core_addr=cnt; next RD_WAIT.
- RD_WAIT: core_op=11, core_addr=cnt (held, so re-reads are stable), out_valid=1, out_re=core_y_re, out_im=core_y_im, out_last=(cnt==N-1).
  - On out_ready: if cnt=N-1, frame_done←1 for 1 cycle, cnt←0, go to IDLE. Otherwise cnt←cnt+1, go to RD_ISSUE.
  - Without out_ready: stay; outputs are unchanged.
- core_reset = reset OR (state==CLR).
- No arithmetic is done on the data; data passes through unmodified.

## Timing
- Reset values: state IDLE; cnt=0; in_ready=0; out_valid=0; out_last=0; out_re/out_im=core_y (don't-care while out_valid=0); busy=0; frame_done=0; error=0; run_cycles=0; core_op=00; core_addr=0; core_x_rns=0; core_reset=1 during reset.
- Reset mid-frame in any state: next cycle is IDLE with reset values. The partial frame is discarded. The core is reset in the same cycle.
- Frame start latency: in_valid rises in IDLE → CLR next cycle → in_ready=1 the cycle after (2 cycles).
- Load takes N accepted handshakes; in_valid gaps insert idle cycles with core_op=00.
- RUN length with a conforming core is N*(N+1)+1 cycles; run_cycles reports the exact count.
- Readout takes 2 cycles per result with out_ready held high, i.e. 2N cycles.
- in_valid during RUN/RD_* is ignored (in_ready=0). A new frame needs IDLE, so there are ≥1 IDLE cycles between frames.
- frame_done and the return to IDLE coincide: frame_done is high in the first IDLE cycle.

## Test plan
- Reset then idle: hold reset 3 cycles with in_valid=0 → all outputs at reset values, core_reset=1 during reset, core_op=00 and busy=0 afterwards.
- N=4 frame with a core model whose results are out[k]={k,k,k,k}; inputs 0x01010101..0x04040404 back-to-back.
  - Core sees writes with addr 0..3 carrying those values.
  - Then core_op=10 until done; outputs are out_re=0x00000000..0x03030303 with out_last only on index 3, then frame_done.
- Backpressure: out_ready low for 5 cycles on index 2 → out_valid stays 1 and out_re stays stable; no index is skipped or duplicated.
- Input gaps: in_valid toggling 1,0,0,1,... → core_op=01 only on handshake cycles, with cnt advancing per accept.
- Timeout: core model never raises done, TIMEOUT=50 → error=1 after 50 RUN cycles, 4 results still drained, frame_done pulses, error clears on next frame start.
- Reset mid-LOAD after 2 samples → IDLE next cycle. A following full frame produces correct results and run_cycles=N*(N+1)+1 (21 for N=4).
